instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Instruction-side responder for the program counter: takes the fetch address driven by the PC register and returns the 32-bit instruction combinationally, as the single-cycle datapath requires.
- Also contains a byte-serial program loader. It fills the instruction RAM before execution and holds the core in reset through `busy` while loading.
- Sits between the PC register output and the instruction decoder. The loader port connects to the host/testbench byte source.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; must be a power of two ≥ 4.
- AW, 8, word-index width; equals log2(DEPTH_WORDS).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- pc_addr  input  32  byte fetch address from PC register
- instr  output  32  fetched instruction
- fetch_fault  output  1  fetch address misaligned or out of range
- load_start  input  1  one-cycle request to begin a program load
- load_valid  input  1  load_byte is valid this cycle
- load_byte  input  8  program byte, big-endian order (MSB byte of each word first)
- load_end  input  1  final-byte marker / terminate load
- load_ready  output  1  loader accepts a byte this cycle
- busy  output  1  load in progress; system holds the core reset while high
- load_done  output  1  one-cycle pulse when a load completes
- load_err  output  1  sticky overflow flag; cleared by the next load_start
- words_loaded  output  AW+1  number of words written by the last or current load

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, load_ready=0, load_done=0, load_err=0, words_loaded=0; byte counter, write pointer and assembly register cleared. RAM contents are not cleared and are retained across reset.
- Fetch path (combinational, zero latency):
  - fetch_fault=1 when pc_addr[1:0]≠0 or pc_addr ≥ DEPTH_WORDS*4.
  - instr = mem[pc_addr[AW+1:2]] when busy=0 and fetch_fault=0; otherwise instr = 32'h00000000 (NOP).
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_ready=0.
  - load_start → LOAD. On that edge: wptr=0, byte_cnt=0, words_loaded=0, load_err=0.
  - busy rises the cycle after load_start.
- LOAD:
  - busy=1; load_ready=1 unless overflow has occurred.
  - A byte transfers on a clock edge with load_valid & load_ready. Byte n of a word (n=0..3) goes to bits [31-8n:24-8n].
  - On the 4th byte, the assembled word is written to mem[wptr] on the same edge; wptr and words_loaded increment; byte_cnt returns to 0.
  - Overflow: a word written at wptr=DEPTH_WORDS-1 sets the internal full condition. Any later valid byte sets load_err=1, is not accepted (load_ready=0 from the cycle after full), and the FSM goes to DONE.
  - load_end, evaluated after any byte transferred on the same edge:
    - byte_cnt≠0 and not full: the partial word is zero-padded in the low bytes and written at wptr; wptr and words_loaded increment.
    - Then → DONE.
  - load_start while in LOAD is ignored.
  - load_valid without load_ready transfers nothing.
- DONE:
  - Lasts one cycle: load_done=1, busy=1, load_ready=0.
  - → IDLE; busy=0 from the next cycle.
- Simultaneous load_start and reset: reset wins.
- Reset mid-load: the partial word is discarded; already-written words remain in RAM.
- Writes occur only on clk edges; a read of the location being written returns the old data until the edge (read-before-write).

Test Plan:
- Load bytes 20 08 00 05 20 09 00 07, load_end with the last byte:
  - mem[0]=0x20080005, mem[1]=0x20090007, words_loaded=2, one load_done pulse, busy low afterward.
  - pc_addr=0 → instr=0x20080005; pc_addr=4 → instr=0x20090007.
- Partial word: bytes AA BB CC DD 11 22, then load_end alone:
  - mem[0]=0xAABBCCDD, mem[1]=0x11220000, words_loaded=2.
- Faults (DEPTH_WORDS=256): pc_addr=0x2 → fetch_fault=1, instr=0; pc_addr=0x400 → fetch_fault=1, instr=0; pc_addr=0x3FC → fetch_fault=0.
- Overflow (DEPTH_WORDS=4): stream 17 bytes.
  - After byte 16, load_ready=0 and words_loaded=4.
  - Byte 17 → load_err=1, DONE, load_done pulse; mem[3] holds bytes 13–16.
- Reset mid-load: assert reset after 5 bytes.
  - Immediately: busy=0, load_ready=0, words_loaded=0.
  - mem[0] retains word 0; a new load_start clears load_err and restarts at wptr=0.
- Busy gating: during LOAD, pc_addr=0 → instr=0x00000000 with fetch_fault=0. Valid instr returns the cycle after DONE.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory with a zero-latency fetch port and a byte-serial program loader.
// The loader assembles big-endian bytes into words and holds the core off (busy) while loading.
module instr_mem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_addr,
  output logic [31:0]   instr,
  output logic          fetch_fault,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  input  logic          load_end,
  output logic          load_ready,
  output logic          busy,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  state_t         state_reg, state_next;
  logic [AW-1:0]  wptr_reg, wptr_next;
  logic [1:0]     byte_cnt_reg, byte_cnt_next;
  logic [31:0]    asm_reg, asm_next;
  logic [AW:0]    words_reg, words_next;
  logic           err_reg, err_next;
  logic           full_reg, full_next;

  logic           xfer;
  logic [31:0]    asm_fill;
  logic           wr_en;
  logic [31:0]    wr_data;

  logic [31:0]    mem [DEPTH_WORDS];

  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    byte_cnt_next = byte_cnt_reg;
    asm_next      = asm_reg;
    words_next    = words_reg;
    err_next      = err_reg;
    full_next     = full_reg;
    xfer          = 1'b0;
    asm_fill      = asm_reg;
    wr_en         = 1'b0;
    wr_data       = asm_reg;
    load_ready    = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_start) begin
          state_next    = LOAD;
          wptr_next     = '0;
          byte_cnt_next = '0;
          asm_next      = '0;
          words_next    = '0;
          err_next      = 1'b0;
          full_next     = 1'b0;
        end
      end

      LOAD: begin
        busy       = 1'b1;
        load_ready = !full_reg;
        xfer       = load_valid && !full_reg;
        // ~byte_cnt selects lane 3-n, so byte 0 lands in bits [31:24]
        if (xfer) asm_fill[{~byte_cnt_reg, 3'b000} +: 8] = load_byte;

        if (xfer) begin
          if (byte_cnt_reg == 2'd3) begin
            wr_en         = 1'b1;
            wr_data       = asm_fill;
            wptr_next     = wptr_reg + 1'b1;
            words_next    = words_reg + 1'b1;
            byte_cnt_next = '0;
            asm_next      = '0;
            if (wptr_reg == LAST_WORD) full_next = 1'b1;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
            asm_next      = asm_fill;
          end
        end

        if (full_reg && load_valid) begin
          err_next   = 1'b1;
          state_next = DONE;
        end

        // Termination sees the byte accepted on this same edge; low bytes stay zero
        if (load_end) begin
          if (byte_cnt_next != 2'd0 && !full_reg) begin
            wr_en         = 1'b1;
            wr_data       = asm_fill;
            wptr_next     = wptr_reg + 1'b1;
            words_next    = words_reg + 1'b1;
            byte_cnt_next = '0;
            asm_next      = '0;
            if (wptr_reg == LAST_WORD) full_next = 1'b1;
          end
          state_next = DONE;
        end
      end

      DONE: begin
        busy       = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wptr_reg     <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      words_reg    <= '0;
      err_reg      <= 1'b0;
      full_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      byte_cnt_reg <= byte_cnt_next;
      asm_reg      <= asm_next;
      words_reg    <= words_next;
      err_reg      <= err_next;
      full_reg     <= full_next;
    end
  end

  // RAM is deliberately outside the reset domain so a program survives a core reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_reg] <= wr_data;
  end

  assign fetch_fault  = (pc_addr[1:0] != 2'b00) || (pc_addr[31:AW+2] != '0);
  assign instr        = (!busy && !fetch_fault) ? mem[pc_addr[AW+1:2]] : 32'h0000_0000;
  assign load_err     = err_reg;
  assign words_loaded = words_reg;

endmodule
